// File: rtl/odd_count_checker.sv
// rtl/odd_count_checker.sv - monitor/decoder for the odd up/down counter bus.
// Optional ODD_CHK_REV_COUNT_EN adds a saturating rev_count output.
module odd_count_checker #(
   parameter int WIDTH      = 4,
   parameter int ERR_W      = 8,
   parameter int MISS_LIMIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] count_in,
   output logic             locked,
   output logic             dir_out,
   output logic [WIDTH-1:0] expected,
   output logic             err_pulse,
   output logic             rev_pulse,
   output logic [ERR_W-1:0] err_count
`ifdef ODD_CHK_REV_COUNT_EN
   ,
   output logic [ERR_W-1:0] rev_count
`endif
);

   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
   localparam logic [MW-1:0]    MISS_LAST = MW'(MISS_LIMIT - 1);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [MW-1:0]    miss_q, miss_d;
   logic             dir_q, dir_d;
   logic             locked_q, locked_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic             err_q, err_d;
   logic             rev_q, rev_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             odd;
   logic [WIDTH-1:0] up_v, dn_v, fwd_v, back_v;

   assign odd    = count_in[0];
   assign up_v   = last_q + TWO;
   assign dn_v   = last_q - TWO;
   assign fwd_v  = dir_q ? up_v : dn_v;
   assign back_v = dir_q ? dn_v : up_v;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      miss_d     = miss_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      rev_d      = 1'b0;
      if (valid_in) begin
         case (state_q)
            IDLE: begin
               if (odd) begin
                  last_d  = count_in;
                  state_d = ACQ;
               end else begin
                  err_d = 1'b1;
               end
            end
            ACQ: begin
               if (!odd) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (count_in == up_v || count_in == dn_v) begin
                  dir_d   = (count_in == up_v);
                  last_d  = count_in;
                  miss_d  = '0;
                  state_d = LOCKED;
               end else begin
                  err_d  = 1'b1;
                  last_d = count_in;
               end
            end
            LOCKED: begin
               if (odd && count_in == fwd_v) begin
                  last_d = count_in;
                  miss_d = '0;
               end else if (odd && count_in == back_v) begin
                  dir_d  = ~dir_q;
                  rev_d  = 1'b1;
                  last_d = count_in;
                  miss_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (miss_q == MISS_LAST) begin
                     state_d = IDLE;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                     if (odd) last_d = count_in;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Prediction is made from the values that will be registered this edge.
      locked_d   = (state_d == LOCKED);
      expected_d = '0;
      if (locked_d) expected_d = dir_d ? (last_d + TWO) : (last_d - TWO);
      err_cnt_d  = (err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= '0;
         miss_q     <= '0;
         dir_q      <= 1'b0;
         locked_q   <= 1'b0;
         expected_q <= '0;
         err_q      <= 1'b0;
         rev_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         miss_q     <= miss_d;
         dir_q      <= dir_d;
         locked_q   <= locked_d;
         expected_q <= expected_d;
         err_q      <= err_d;
         rev_q      <= rev_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

`ifdef ODD_CHK_REV_COUNT_EN
   logic [ERR_W-1:0] rev_cnt_q, rev_cnt_d;

   assign rev_cnt_d = (rev_d && rev_cnt_q != '1) ? rev_cnt_q + 1'b1 : rev_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rev_cnt_q <= '0;
      else       rev_cnt_q <= rev_cnt_d;
   end

   assign rev_count = rev_cnt_q;
`endif

   assign locked    = locked_q;
   assign dir_out   = dir_q;
   assign expected  = expected_q;
   assign err_pulse = err_q;
   assign rev_pulse = rev_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_odd_count_checker.sv
// tb/tb_odd_count_checker.sv - directed-vector bench for odd_count_checker.
module tb_odd_count_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid_in = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       locked, dir_out, err_pulse, rev_pulse;
   logic [3:0] expected;
   logic [7:0] err_count;
`ifdef ODD_CHK_REV_COUNT_EN
   logic [7:0] rev_count;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   odd_count_checker #(.WIDTH(4), .ERR_W(8), .MISS_LIMIT(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .count_in  (count_in),
      .locked    (locked),
      .dir_out   (dir_out),
      .expected  (expected),
      .err_pulse (err_pulse),
      .rev_pulse (rev_pulse),
      .err_count (err_count)
`ifdef ODD_CHK_REV_COUNT_EN
      ,
      .rev_count (rev_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One valid sample; returns at the following falling edge with outputs settled.
   task automatic smp(input logic [3:0] v);
      @(negedge clk);
      valid_in = 1'b1;
      count_in = v;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      check_eq("rst_locked", {7'd0, locked}, 8'd0);
      check_eq("rst_dir", {7'd0, dir_out}, 8'd0);
      check_eq("rst_expected", {4'd0, expected}, 8'd0);
      check_eq("rst_err_count", err_count, 8'd0);

      // 1: lock upward
      smp(4'd1);
      check_eq("t1_acq_locked", {7'd0, locked}, 8'd0);
      smp(4'd3);
      check_eq("t1_locked", {7'd0, locked}, 8'd1);
      check_eq("t1_dir", {7'd0, dir_out}, 8'd1);
      check_eq("t1_exp2", {4'd0, expected}, 8'd5);
      smp(4'd5);
      check_eq("t1_exp3", {4'd0, expected}, 8'd7);
      check_eq("t1_errcnt", err_count, 8'd0);

      // 2: upward wrap 15 -> 1
      do_reset();
      smp(4'd11);
      smp(4'd13);
      smp(4'd15);
      check_eq("t2_exp15", {4'd0, expected}, 8'd1);
      smp(4'd1);
      check_eq("t2_err_wrap", {7'd0, err_pulse}, 8'd0);
      smp(4'd3);
      check_eq("t2_locked", {7'd0, locked}, 8'd1);
      check_eq("t2_exp", {4'd0, expected}, 8'd5);
      check_eq("t2_errcnt", err_count, 8'd0);

      // 3: legal reversal
      do_reset();
      smp(4'd1); smp(4'd3); smp(4'd5); smp(4'd7);
      smp(4'd5);
      check_eq("t3_rev", {7'd0, rev_pulse}, 8'd1);
      check_eq("t3_rev_noerr", {7'd0, err_pulse}, 8'd0);
      check_eq("t3_dir", {7'd0, dir_out}, 8'd0);
      check_eq("t3_exp_rev", {4'd0, expected}, 8'd3);
      @(negedge clk);
      check_eq("t3_rev_oneshot", {7'd0, rev_pulse}, 8'd0);
      smp(4'd3);
      check_eq("t3_rev_after", {7'd0, rev_pulse}, 8'd0);
      check_eq("t3_exp", {4'd0, expected}, 8'd1);
      check_eq("t3_errcnt", err_count, 8'd0);

      // 4: miss limit drops lock
      do_reset();
      smp(4'd1); smp(4'd3); smp(4'd5);
      smp(4'd9);
      check_eq("t4_err1", {7'd0, err_pulse}, 8'd1);
      check_eq("t4_cnt1", err_count, 8'd1);
      check_eq("t4_locked1", {7'd0, locked}, 8'd1);
      check_eq("t4_exp1", {4'd0, expected}, 8'd11);
      smp(4'd13);
      check_eq("t4_err2", {7'd0, err_pulse}, 8'd1);
      check_eq("t4_cnt2", err_count, 8'd2);
      check_eq("t4_unlocked", {7'd0, locked}, 8'd0);
      check_eq("t4_exp_idle", {4'd0, expected}, 8'd0);

      // reversal clears a pending miss
      do_reset();
      smp(4'd1); smp(4'd3); smp(4'd5);
      smp(4'd9);
      smp(4'd7);
      check_eq("rc_rev", {7'd0, rev_pulse}, 8'd1);
      check_eq("rc_noerr", {7'd0, err_pulse}, 8'd0);
      smp(4'd11);
      check_eq("rc_err", {7'd0, err_pulse}, 8'd1);
      check_eq("rc_still_locked", {7'd0, locked}, 8'd1);
      check_eq("rc_cnt", err_count, 8'd2);

      // 5: even sample in IDLE, then downward lock and wrap 1 -> 15
      do_reset();
      smp(4'd4);
      check_eq("t5_err", {7'd0, err_pulse}, 8'd1);
      check_eq("t5_cnt", err_count, 8'd1);
      check_eq("t5_idle", {7'd0, locked}, 8'd0);
      smp(4'd7);
      smp(4'd5);
      check_eq("t5_locked", {7'd0, locked}, 8'd1);
      check_eq("t5_dir", {7'd0, dir_out}, 8'd0);
      check_eq("t5_exp", {4'd0, expected}, 8'd3);
      smp(4'd3); smp(4'd1); smp(4'd15);
      check_eq("t5_wrap_noerr", {7'd0, err_pulse}, 8'd0);
      check_eq("t5_wrap_exp", {4'd0, expected}, 8'd13);
      check_eq("t5_wrap_cnt", err_count, 8'd1);

      // ACQ errors: bad odd step stays in ACQ, even returns to IDLE
      do_reset();
      smp(4'd1);
      smp(4'd7);
      check_eq("acq_bad_err", {7'd0, err_pulse}, 8'd1);
      smp(4'd9);
      check_eq("acq_relock", {7'd0, locked}, 8'd1);
      do_reset();
      smp(4'd1);
      smp(4'd2);
      check_eq("acq_even_err", {7'd0, err_pulse}, 8'd1);
      smp(4'd3);
      check_eq("acq_even_idle", {7'd0, locked}, 8'd0);
      smp(4'd5);
      check_eq("acq_even_lock", {7'd0, locked}, 8'd1);

      // 6: valid gaps, then asynchronous reset between edges
      do_reset();
      smp(4'd1); smp(4'd3); smp(4'd5);
      repeat (3) @(negedge clk);
      check_eq("t6_gap_exp", {4'd0, expected}, 8'd7);
      check_eq("t6_gap_locked", {7'd0, locked}, 8'd1);
      check_eq("t6_gap_err", {7'd0, err_pulse}, 8'd0);
      smp(4'd7);
      check_eq("t6_after_gap", {4'd0, expected}, 8'd9);
      smp(4'd8);
      check_eq("t6_even_cnt", err_count, 8'd1);
      check_eq("t6_even_locked", {7'd0, locked}, 8'd1);
      #2 reset = 1'b1;
      #1;
      check_eq("t6_async_locked", {7'd0, locked}, 8'd0);
      check_eq("t6_async_dir", {7'd0, dir_out}, 8'd0);
      check_eq("t6_async_exp", {4'd0, expected}, 8'd0);
      check_eq("t6_async_err", {7'd0, err_pulse}, 8'd0);
      check_eq("t6_async_cnt", err_count, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      smp(4'd9);
      check_eq("t6_post_idle", {7'd0, locked}, 8'd0);
      check_eq("t6_post_noerr", {7'd0, err_pulse}, 8'd0);
      smp(4'd11);
      check_eq("t6_post_lock", {7'd0, locked}, 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
